rank_filter_sequencer: RTL
==========================

# rank_filter_sequencer

Parametrised run controller for the rank-order filter datapath. It replaces the gated-clock sample stepping with a single-clock, clock-enable-driven sequence: it reads source samples from a synchronous ROM, drives the filter's clock enable, and writes filter results into a result RAM at a latency-compensated address. It also keeps a wrapping browse pointer for the display path, and supports start/abort, single-shot and looping runs.

## Interface
Parameters:
- ADDR_BITS, 8, width of source, result and browse addresses
- NUM_SAMPLES, 255, samples per run; range 1..2**ADDR_BITS
- FILTER_LAT, 3, filter latency in clock cycles from filter enable to output; 0 allowed

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  run request, single-cycle pulse
- abort  in  1  cancel current run
- loop  in  1  1 = restart automatically after each run
- step_up  in  1  browse +1, debounced single-cycle pulse
- step_down  in  1  browse -1, debounced single-cycle pulse
- src_rd_en  out  1  ROM read strobe
- src_addr  out  ADDR_BITS  ROM address
- filt_ce  out  1  filter clock enable; ROM data is valid while high
- wr_en  out  1  result RAM write enable
- wr_addr  out  ADDR_BITS  result RAM write address
- rd_addr  out  ADDR_BITS  browse/display read address
- busy  out  1  high in RUN and DRAIN
- done  out  1  high while in DONE

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. On reset: state IDLE; every output 0; delay lines cleared.
- IDLE/DONE + start -> RUN. The cycle that enters RUN has src_addr=0 and src_rd_en=1.
- RUN: src_rd_en=1 and src_addr increments by 1 per cycle. After the cycle with src_addr=NUM_SAMPLES-1, the next state is DRAIN. In DRAIN, src_rd_en=0 and src_addr holds.
- filt_ce is src_rd_en delayed by 1 cycle, to match the ROM read latency.
- wr_en is filt_ce delayed by FILTER_LAT cycles, through a shift register.
- wr_addr resets to 0 on entry to RUN and increments after each write.
- DRAIN -> DONE in the cycle after the NUM_SAMPLES-th write.
- DONE: done=1.
  - If loop=1, the next state is RUN, so done lasts one cycle.
  - If loop=0, the FSM stays in DONE until start.
- start while busy is ignored.
- abort in RUN or DRAIN: next state IDLE. src_rd_en, filt_ce and wr_en are low from that cycle on, and the delay line is flushed. abort has priority over every other transition. abort in IDLE or DONE is ignored.
- Browse pointer, active in all states:
  - step_up: rd_addr+1, wrapping NUM_SAMPLES-1 -> 0.
  - step_down: rd_addr-1, wrapping 0 -> NUM_SAMPLES-1.
  - step_up and step_down together: no change.
  - rd_addr is cleared only by reset.
- Counters are ADDR_BITS wide. Compare against NUM_SAMPLES-1 explicitly; never rely on natural overflow. NUM_SAMPLES=2**ADDR_BITS must still work.

## Timing
- All outputs are registered.
- Cycle 0 is the first cycle in RUN:
  - src_rd_en is high on cycles 0..NUM_SAMPLES-1, with src_addr equal to the cycle number.
  - filt_ce is high on cycles 1..NUM_SAMPLES.
  - wr_en is high on cycles 1+FILTER_LAT..NUM_SAMPLES+FILTER_LAT, with wr_addr = cycle-1-FILTER_LAT.
  - done first rises on cycle NUM_SAMPLES+FILTER_LAT+1.
- Loop restart: the cycle after the one-cycle DONE is the new cycle 0.
- Reset mid-run: outputs go to 0 immediately (asynchronous). The FSM resumes in IDLE on the first clk edge after rst is released.
- Browse: rd_addr updates on the clk edge that samples the step pulse.

## Structure
- The shared package holds:
  - the state encoding (2-bit: IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - the parameter-check function asserting 1 <= NUM_SAMPLES <= 2**ADDR_BITS.
- Sub-module wrap_counter (parameters WIDTH, MAX): up/down/enable with wrap. It is used for rd_addr. It is also the natural implementation for src_addr and wr_addr, with down tied low.
- The delay lines are local shift registers. With FILTER_LAT=0 the filt_ce -> wr_en line is a plain wire.

## Test plan
Bench uses NUM_SAMPLES=8, FILTER_LAT=3 unless stated.
- start pulse from IDLE -> src_addr 0..7 on cycles 0..7; filt_ce on cycles 1..8; wr_en on cycles 4..11 with wr_addr 0..7; done=1 from cycle 12 and held; busy low.
- loop=1 with one start -> done pulses for exactly 1 cycle every 13 cycles; src_addr restarts at 0; three consecutive runs write addresses 0..7 each time.
- abort on cycle 5 -> state IDLE on cycle 6; src_rd_en, filt_ce and wr_en low from then on; no further writes; a subsequent start restarts at src_addr 0.
- Browse wrap -> from rd_addr=0, step_down gives 7 and step_up then gives 0; step_up and step_down together leave rd_addr unchanged.
- rst asserted on cycle 6 of a run -> all outputs 0 immediately; after release, no activity until start.
- Edge parameters: FILTER_LAT=0, NUM_SAMPLES=256, ADDR_BITS=8 -> wr_en coincides with filt_ce; 256 writes with addresses 0..255 and no overflow skip; done on cycle 257.

Source files
------------

// File: rtl/rank_filter_sequencer_pkg.sv
// Shared state encoding and parameter sanity check for the rank-order filter
// run controller.
package rank_filter_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // True when 1 <= num_samples <= 2**addr_bits.
  function automatic bit params_ok(input int addr_bits, input int num_samples);
    longint span;
    span = longint'(1) << addr_bits;
    return (num_samples >= 1) && (longint'(num_samples) <= span);
  endfunction

endpackage

// File: rtl/rank_filter_sequencer_wrap_counter.sv
// Up/down counter that wraps between 0 and MAX, with synchronous clear.
// Up and down together leave the count unchanged.
module wrap_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    // NOTE: count_d gets a default before any branch so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && up_i && !down_i) begin
      count_d = (count_q == MAX_C) ? '0 : count_q + ONE_C;
    end else if (en_i && down_i && !up_i) begin
      count_d = (count_q == '0) ? MAX_C : count_q - ONE_C;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/rank_filter_sequencer.sv
// Single-clock run controller: steps the source ROM, drives the filter clock
// enable, writes latency-compensated results and keeps the browse pointer.
module rank_filter_sequencer
  import rank_filter_sequencer_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int NUM_SAMPLES = 255,
  parameter int FILTER_LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 loop,
  input  logic                 step_up,
  input  logic                 step_down,
  output logic                 src_rd_en,
  output logic [ADDR_BITS-1:0] src_addr,
  output logic                 filt_ce,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_SAMPLES - 1);

  if (!params_ok(ADDR_BITS, NUM_SAMPLES) || FILTER_LAT < 0) begin : g_bad_params
    $error("rank_filter_sequencer: NUM_SAMPLES must be 1..2**ADDR_BITS and FILTER_LAT >= 0");
  end

  seq_state_e           state_q, state_d;
  logic                 src_rd_en_q, src_rd_en_d;
  logic                 filt_ce_q;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 flush, run_entry, src_step, wr_en_w;
  logic [ADDR_BITS-1:0] src_addr_w, wr_addr_w, rd_addr_w;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (abort)                        state_d = ST_IDLE;
        else if (src_addr_w == LAST_ADDR) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)                                  state_d = ST_IDLE;
        else if (wr_en_w && wr_addr_w == LAST_ADDR) state_d = ST_DONE;
      end
      ST_DONE:  if (start || loop) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    src_rd_en_d = (state_d == ST_RUN);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
  end

  assign flush     = abort && (state_q == ST_RUN || state_q == ST_DRAIN);
  assign run_entry = (state_d == ST_RUN) && (state_q != ST_RUN);
  // Source address freezes on the last sample so it holds through DRAIN.
  assign src_step  = (state_q == ST_RUN) && (state_d == ST_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      src_rd_en_q <= 1'b0;
      filt_ce_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_rd_en_q <= src_rd_en_d;
      filt_ce_q   <= src_rd_en_q && !flush;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // filt_ce -> wr_en delay matching the filter pipeline depth.
  if (FILTER_LAT == 0) begin : g_lat0
    assign wr_en_w = filt_ce_q;
  end else begin : g_lat
    logic [FILTER_LAT-1:0] lat_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lat_q <= '0;
      end else if (flush) begin
        lat_q <= '0;
      end else begin
        lat_q[0] <= filt_ce_q;
        for (int i = 1; i < FILTER_LAT; i++) lat_q[i] <= lat_q[i-1];
      end
    end
    assign wr_en_w = lat_q[FILTER_LAT-1];
  end

  wrap_counter #(.WIDTH(ADDR_BITS), .MAX(NUM_SAMPLES - 1)) u_src_cnt (
    .clk(clk), .rst(rst), .clr_i(run_entry), .en_i(src_step),
    .up_i(1'b1), .down_i(1'b0), .count_o(src_addr_w)
  );

  wrap_counter #(.WIDTH(ADDR_BITS), .MAX(NUM_SAMPLES - 1)) u_wr_cnt (
    .clk(clk), .rst(rst), .clr_i(run_entry), .en_i(wr_en_w),
    .up_i(1'b1), .down_i(1'b0), .count_o(wr_addr_w)
  );

  wrap_counter #(.WIDTH(ADDR_BITS), .MAX(NUM_SAMPLES - 1)) u_rd_cnt (
    .clk(clk), .rst(rst), .clr_i(1'b0), .en_i(1'b1),
    .up_i(step_up), .down_i(step_down), .count_o(rd_addr_w)
  );

  assign src_rd_en = src_rd_en_q;
  assign src_addr  = src_addr_w;
  assign filt_ce   = filt_ce_q;
  assign wr_en     = wr_en_w;
  assign wr_addr   = wr_addr_w;
  assign rd_addr   = rd_addr_w;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
